// File: rtl/abp_sender_if.sv
// Purpose : AXI-Stream style byte channel (valid/ready/last/data) used for the
//           user payload, link frame and ack ports of abp_sender.
// Signals : tvalid/tlast/tdata driven by the master, tready driven by the slave.
interface abp_sender_if #(
    parameter int DW = 8
);
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input  tready);
    modport slave  (input  tvalid, input  tlast, input  tdata, output tready);
endinterface

// File: rtl/abp_sender.sv
// Purpose     : alternating-bit-protocol sender. Buffers one payload frame,
//               sends {header(seq_bit), payload}, waits for a matching ack and
//               retransmits the whole frame on timeout.
// Latency     : header valid the cycle after the last payload byte is accepted;
//               LOAD re-entered the cycle after a matching ack.
// Backpressure: payload input stalls (tready=0) outside LOAD; link output holds
//               data/last stable until m_axis.tready; ack input never stalls.
// Ports: aclk, aresetn (async active-low); s_axis (payload in, slave),
//        m_axis (link out, master), ack_axis (ack in, slave, tdata[0] = ack bit);
//        seq_bit, busy, retx_count status outputs.
// Optional: define ABP_SENDER_STATS_EN to enable the saturating retransmit
//           counter on retx_count; otherwise retx_count is tied to 0.
module abp_sender #(
    parameter int MAX_FRAME_BYTES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic          aclk,
    input  logic          aresetn,
    abp_sender_if.slave   s_axis,
    abp_sender_if.master  m_axis,
    abp_sender_if.slave   ack_axis,
    output logic          seq_bit,
    output logic          busy,
    output logic [15:0]   retx_count
);
    localparam int LW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int AW = $clog2(MAX_FRAME_BYTES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [LW-1:0] LEN_LAST = LW'(MAX_FRAME_BYTES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_DATA = 2'd2,
        WAIT_ACK  = 2'd3
    } state_t;

    state_t        state_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] rd_q;
    logic [TW-1:0] timer_q;
    logic          seq_q;

    logic [7:0]    buf_mem [MAX_FRAME_BYTES];

    logic          frame_last;
    logic          ack_match;
    logic          timeout_hit;
    logic          unused_ack_bits;

    assign frame_last  = (rd_q == len_q - LW'(1));
    assign ack_match   = ack_axis.tvalid && (ack_axis.tdata[0] == seq_q);
    assign timeout_hit = (timer_q == TMR_LAST);

    // Only tdata[0] of an ack beat carries information.
    assign unused_ack_bits = &{1'b0, ack_axis.tlast, ack_axis.tdata[7:1]};

    // Status and handshake outputs decode straight from the state register so
    // an asynchronous reset drops m_axis.tvalid immediately.
    assign s_axis.tready   = (state_q == LOAD);
    assign ack_axis.tready = 1'b1;
    assign busy            = (state_q != LOAD);
    assign seq_bit         = seq_q;

    assign m_axis.tvalid = (state_q == SEND_HDR) || (state_q == SEND_DATA);
    assign m_axis.tlast  = (state_q == SEND_DATA) && frame_last;
    assign m_axis.tdata  = (state_q == SEND_HDR)  ? {7'b0, seq_q} :
                           (state_q == SEND_DATA) ? buf_mem[rd_q[AW-1:0]] :
                                                    8'h00;

    // Payload storage has no reset: contents are meaningless until len_q
    // says otherwise. Writes happen only in LOAD, so a retransmit reads the
    // identical bytes.
    always_ff @(posedge aclk) begin
        if (state_q == LOAD && s_axis.tvalid) begin
            buf_mem[len_q[AW-1:0]] <= s_axis.tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= LOAD;
            len_q   <= '0;
            rd_q    <= '0;
            timer_q <= '0;
            seq_q   <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (s_axis.tvalid) begin
                        len_q <= len_q + LW'(1);
                        // A full buffer closes the frame even without tlast;
                        // the following byte starts the next frame.
                        if (s_axis.tlast || len_q == LEN_LAST) begin
                            state_q <= SEND_HDR;
                        end
                    end
                end
                SEND_HDR: begin
                    if (m_axis.tready) begin
                        rd_q    <= '0;
                        state_q <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (m_axis.tready) begin
                        if (frame_last) begin
                            timer_q <= '0;
                            state_q <= WAIT_ACK;
                        end else begin
                            rd_q <= rd_q + LW'(1);
                        end
                    end
                end
                WAIT_ACK: begin
                    // A matching ack takes priority over a coincident timeout.
                    if (ack_match) begin
                        seq_q   <= ~seq_q;
                        len_q   <= '0;
                        state_q <= LOAD;
                    end else if (timeout_hit) begin
                        state_q <= SEND_HDR;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

`ifdef ABP_SENDER_STATS_EN
    logic [15:0] retx_q;
    logic        retx_fire;

    assign retx_fire = (state_q == WAIT_ACK) && !ack_match && timeout_hit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            retx_q <= '0;
        end else if (retx_fire && retx_q != 16'hFFFF) begin
            retx_q <= retx_q + 16'd1;
        end
    end

    assign retx_count = retx_q;
`else
    assign retx_count = 16'h0000;
`endif

endmodule

// File: tb/tb_abp_sender.sv
// Purpose     : self-checking bench for abp_sender (MAX_FRAME_BYTES=4, TIMEOUT_CYCLES=8).
// Latency     : stimulus pushes expected link beats; a monitor pops them on handshakes.
// Backpressure: m_axis.tready is either held high or randomised per cycle.
module tb_abp_sender;
    localparam int MAXB = 4;
    localparam int TMO  = 8;
`ifdef ABP_SENDER_STATS_EN
    localparam logic [15:0] RETX_STEP = 16'd1;
`else
    localparam logic [15:0] RETX_STEP = 16'd0;
`endif

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        seq_bit;
    logic        busy;
    logic [15:0] retx_count;

    abp_sender_if s_if   ();
    abp_sender_if m_if   ();
    abp_sender_if ack_if ();

    abp_sender #(.MAX_FRAME_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .ack_axis   (ack_if),
        .seq_bit    (seq_bit),
        .busy       (busy),
        .retx_count (retx_count)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int rdy_mode = 0;   // 0: ready held high, 1: random ready
    always begin
        m_if.tready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge aclk);
        #1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard: {tlast, tdata} per expected link beat.
    logic [8:0] exp_q[$];

    task automatic push(input logic l, input logic [7:0] d);
        exp_q.push_back({l, d});
    endtask

    // Monitor: compare each link handshake with the scoreboard and check that
    // a stalled beat keeps valid, data and last stable.
    initial begin
        logic       stall;
        logic [8:0] prev_beat;
        logic [8:0] e;
        stall     = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid_held", 32'(m_if.tvalid), 32'd1);
                    chk("stall_beat_stable", {23'b0, m_if.tlast, m_if.tdata}, {23'b0, prev_beat});
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        bound_fail("unexpected_link_beat");
                    end else begin
                        e = exp_q.pop_front();
                        chk("link_beat", {23'b0, m_if.tlast, m_if.tdata}, {23'b0, e});
                    end
                end
                stall     = m_if.tvalid && !m_if.tready;
                prev_beat = {m_if.tlast, m_if.tdata};
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (s_if.tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("send_byte");
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_ack(input logic [7:0] d);
        ack_if.tvalid = 1'b1;
        ack_if.tdata  = d;
        @(negedge aclk);
        chk("ack_tready", 32'(ack_if.tready), 32'd1);
        @(posedge aclk);
        #1;
        ack_if.tvalid = 1'b0;
    endtask

    // Returns the cycle of the handshake carrying tlast.
    task automatic wait_last(output int m);
        m = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (m_if.tvalid && m_if.tready && m_if.tlast) begin
                m = cyc;
                break;
            end
        end
        if (m < 0) bound_fail("wait_last");
    endtask

    // Returns the first cycle (after the next edge) with link valid high.
    task automatic wait_hdr(output int h);
        h = -1;
        @(posedge aclk);
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (m_if.tvalid) begin
                h = cyc;
                break;
            end
        end
        if (h < 0) bound_fail("wait_hdr");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_chk++;
        n_fail++;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int m2;
        int h;
        s_if.tvalid   = 1'b0;
        s_if.tlast    = 1'b0;
        s_if.tdata    = 8'h00;
        ack_if.tvalid = 1'b0;
        ack_if.tlast  = 1'b0;
        ack_if.tdata  = 8'h00;
        aresetn       = 1'b0;

        // Reset values
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_s_tready",   32'(s_if.tready),   32'd1);
        chk("rst_m_tvalid",   32'(m_if.tvalid),   32'd0);
        chk("rst_m_tlast",    32'(m_if.tlast),    32'd0);
        chk("rst_m_tdata",    32'(m_if.tdata),    32'd0);
        chk("rst_ack_tready", 32'(ack_if.tready), 32'd1);
        chk("rst_seq_bit",    32'(seq_bit),       32'd0);
        chk("rst_busy",       32'(busy),          32'd0);
        chk("rst_retx",       32'(retx_count),    32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Single frame A1 A2 A3, ack 0x00 five cycles after the frame
        push(1'b0, 8'h00); push(1'b0, 8'hA1); push(1'b0, 8'hA2); push(1'b1, 8'hA3);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b1);
        chk("hdr_valid_next_cycle", 32'(m_if.tvalid), 32'd1);
        chk("hdr_data_seq0",        32'(m_if.tdata),  32'h00);
        chk("busy_while_sending",   32'(busy),        32'd1);
        chk("s_tready_low_busy",    32'(s_if.tready), 32'd0);
        wait_last(m);
        repeat (5) @(posedge aclk);
        #1;
        send_ack(8'h00);
        chk("t1_seq_toggled", 32'(seq_bit),     32'd1);
        chk("t1_busy_low",    32'(busy),        32'd0);
        chk("t1_s_tready",    32'(s_if.tready), 32'd1);

        // Wrong ack with seq_bit=1: ignored, timer keeps running
        push(1'b0, 8'h01); push(1'b1, 8'hC1);
        push(1'b0, 8'h01); push(1'b1, 8'hC1);
        send_byte(8'hC1, 1'b1);
        wait_last(m);
        @(posedge aclk);
        #1;
        send_ack(8'h00);
        chk("wrong_ack_busy", 32'(busy),    32'd1);
        chk("wrong_ack_seq",  32'(seq_bit), 32'd1);
        wait_hdr(h);
        chk("wrong_ack_retx_delay", 32'(h - m), 32'(TMO + 1));
        wait_last(m2);
        @(posedge aclk);
        #1;
        send_ack(8'h01);
        chk("t2_seq_back_0", 32'(seq_bit),    32'd0);
        chk("t2_busy_low",   32'(busy),       32'd0);
        chk("t2_retx_count", 32'(retx_count), 32'(RETX_STEP));

        // Timeout: 2-byte frame resent exactly TMO cycles after WAIT_ACK entry
        push(1'b0, 8'h00); push(1'b0, 8'hB1); push(1'b1, 8'hB2);
        push(1'b0, 8'h00); push(1'b0, 8'hB1); push(1'b1, 8'hB2);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b1);
        wait_last(m);
        wait_hdr(h);
        chk("timeout_retx_delay", 32'(h - m), 32'(TMO + 1));
        wait_last(m2);
        chk("t3_retx_count", 32'(retx_count), 32'(16'd2 * RETX_STEP));
        @(posedge aclk);
        #1;
        send_ack(8'h00);
        chk("t3_seq", 32'(seq_bit), 32'd1);

        // Reset during SEND_DATA
        push(1'b0, 8'h01); push(1'b0, 8'hC7);
        send_byte(8'hC7, 1'b0);
        send_byte(8'hC8, 1'b0);
        send_byte(8'hC9, 1'b1);
        @(negedge aclk);
        @(negedge aclk);
        chk("pre_reset_in_data", 32'(m_if.tdata), 32'hC7);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 32'(m_if.tvalid),   32'd0);
        chk("mid_rst_seq",      32'(seq_bit),       32'd0);
        chk("mid_rst_busy",     32'(busy),          32'd0);
        chk("mid_rst_retx",     32'(retx_count),    32'd0);
        chk("sb_empty_at_rst",  32'(exp_q.size()),  32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        push(1'b0, 8'h00); push(1'b1, 8'hD0);
        send_byte(8'hD0, 1'b1);
        wait_last(m);
        @(posedge aclk);
        #1;
        send_ack(8'h00);
        chk("t4_seq", 32'(seq_bit), 32'd1);

        // Random backpressure, then matching ack on the timeout cycle
        rdy_mode = 1;
        push(1'b0, 8'h01); push(1'b0, 8'hD1); push(1'b0, 8'hD2); push(1'b1, 8'hD3);
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_byte(8'hD3, 1'b1);
        wait_last(m);
        repeat (TMO) @(posedge aclk);
        #1;
        send_ack(8'h01);
        rdy_mode = 0;
        chk("collide_no_retx_valid", 32'(m_if.tvalid), 32'd0);
        chk("collide_busy",          32'(busy),        32'd0);
        chk("collide_seq",           32'(seq_bit),     32'd0);
        chk("collide_retx_count",    32'(retx_count),  32'd0);

        // Overflow: 6 bytes into a 4-byte buffer, tlast only on byte 6
        push(1'b0, 8'h00); push(1'b0, 8'hE1); push(1'b0, 8'hE2);
        push(1'b0, 8'hE3); push(1'b1, 8'hE4);
        push(1'b0, 8'h01); push(1'b0, 8'hE5); push(1'b1, 8'hE6);
        fork
            begin
                send_byte(8'hE1, 1'b0);
                send_byte(8'hE2, 1'b0);
                send_byte(8'hE3, 1'b0);
                send_byte(8'hE4, 1'b0);
                send_byte(8'hE5, 1'b0);
                send_byte(8'hE6, 1'b1);
            end
            begin
                wait_last(m);
                @(posedge aclk);
                #1;
                send_ack(8'h00);
            end
        join
        wait_last(m2);
        @(posedge aclk);
        #1;
        send_ack(8'h01);
        chk("t6_seq", 32'(seq_bit), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        repeat (5) @(posedge aclk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/abp_sender.md
# abp_sender

Transmit side of the alternating bit protocol, directly upstream of `abp_receiver`. Buffers one payload frame from a user AXI-Stream and prefixes a header byte carrying the current sequence bit. Sends the frame to the link, then holds it until a matching acknowledgement returns. Retransmits the whole frame on timeout and toggles the sequence bit on each accepted ack.

## Interface
- `MAX_FRAME_BYTES`, 16: payload buffer depth in bytes (2..256).
- `TIMEOUT_CYCLES`, 1000: cycles spent in WAIT_ACK before retransmit (≥2).
- `aclk` in 1: clock.
- `aresetn` in 1: reset. Asynchronous assert, active-low; the block has one clock.
- `s_axis_tvalid` / `s_axis_tready` / `s_axis_tlast` / `s_axis_tdata`: in / out / in / in, widths 1 / 1 / 1 / 8. User payload stream.
- `m_axis_tvalid` / `m_axis_tready` / `m_axis_tlast` / `m_axis_tdata`: out / in / out / out, widths 1 / 1 / 1 / 8. Link frame stream toward `abp_receiver`.
- `ack_axis_tvalid` / `ack_axis_tready` / `ack_axis_tdata`: in / out / in, widths 1 / 1 / 8. Returned ack beats; `tdata[0]` is the ack bit.
- `seq_bit` out 1: sequence bit of the frame currently owned.
- `busy` out 1: high in any state other than LOAD.
- `retx_count` out 16: retransmission count. See Configuration.

## Operation
- States are LOAD, SEND_HDR, SEND_DATA and WAIT_ACK. Reset enters LOAD.
- **LOAD**
  - `s_axis_tready=1`; each accepted byte is written to the buffer and `len` increments.
  - An accepted byte with `tlast=1` goes to SEND_HDR.
  - The byte that makes `len==MAX_FRAME_BYTES` is treated as last even without `tlast`. The next byte starts a new frame.
  - A zero-length frame is impossible, since a frame needs at least one accepted byte.
- **SEND_HDR**
  - Drives `m_axis_tdata={7'b0,seq_bit}` with `tlast=0`.
  - On handshake, goes to SEND_DATA with read pointer 0.
- **SEND_DATA**
  - Drives `buf[rd]`, with `tlast=1` when `rd==len-1`.
  - On the last handshake, goes to WAIT_ACK and clears the timer.
- **WAIT_ACK**
  - Timer increments every cycle.
  - Ack beat with `tdata[0]==seq_bit`: `seq_bit` toggles, `len` clears, next state is LOAD.
  - Mismatched ack: discarded, timer keeps running.
  - Timer reaches `TIMEOUT_CYCLES-1` with no matching ack: goes to SEND_HDR and resends the identical frame with the same `seq_bit`. The buffer is preserved.
  - Matching ack and timeout in the same cycle: the ack wins and there is no retransmit.
- **Ack channel:** `ack_axis_tready=1` in all states. Beats outside WAIT_ACK are consumed and ignored; stale acks must not stall the link.
- **AXIS rules:**
  - Once `m_axis_tvalid` is high, `m_axis_tdata` and `m_axis_tlast` stay stable until `m_axis_tready`.
  - `m_axis_tvalid` never drops without a handshake.
- **Widths:**
  - `len` and `rd` are `$clog2(MAX_FRAME_BYTES+1)` bits.
  - The timer is `$clog2(TIMEOUT_CYCLES)` bits and saturates if ever reached.
- **Reset mid-operation:** the frame is discarded, `seq_bit` returns to 0 and the state returns to LOAD.

## Timing
- Reset values:
  - `s_axis_tready=1`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`.
  - `ack_axis_tready=1`, `seq_bit=0`, `busy=0`, `retx_count=0`.
- Last payload byte accepted in cycle N: header valid in N+1, first payload byte available in N+2 if `m_axis_tready` is held high.
- Frame of L payload bytes with `m_axis_tready=1`: the link sees L+1 consecutive beats.
- Last link handshake in cycle M: WAIT_ACK from M+1, with timer=0 at M+1.
- Matching ack in cycle K: LOAD, toggled `seq_bit` and `s_axis_tready=1` are all visible at K+1.
- Timeout: a WAIT_ACK entered at M+1 with no matching ack retransmits the header at cycle M+1+TIMEOUT_CYCLES.
- `s_axis_tready` and `busy` are decoded directly from the state register. `m_axis_*` comes from registers and buffer read.

## Configuration
- `ABP_SENDER_STATS_EN` defined:
  - `retx_count` increments by 1 on each timeout-triggered retransmit and saturates at 16'hFFFF.
  - It clears only on reset.
- Macro undefined: the counter logic is absent and `retx_count` is tied to 0.

## Test plan
- **Single frame.** Send payload 0xA1,0xA2,0xA3 with `tlast` on 0xA3, hold `m_axis_tready=1`, return ack 0x00 five cycles after the frame.
  - Link carries 0x00,0xA1,0xA2,0xA3 with `tlast` on 0xA3.
  - `seq_bit` becomes 1 and `busy` falls the cycle after the ack.
- **Timeout.** `TIMEOUT_CYCLES=8`, send a 2-byte frame and give no ack.
  - Identical 3-beat frame resends exactly 8 cycles after WAIT_ACK entry.
  - `retx_count=1` with `ABP_SENDER_STATS_EN`, 0 without.
- **Wrong ack.** With `seq_bit=1` in WAIT_ACK, send ack 0x00, then 0x01.
  - The first ack is ignored and the timer keeps counting.
  - The second ack returns the block to LOAD with `seq_bit=0`.
- **Backpressure and collision.**
  - Toggle `m_axis_tready` randomly: data and `tlast` stay stable while valid is high, and no beat is lost or duplicated.
  - Deliver the matching ack on the timeout cycle: no retransmit occurs.
- **Overflow.** `MAX_FRAME_BYTES=4`, send 6 bytes with `tlast` only on byte 6.
  - First frame carries bytes 1..4 with `tlast` on byte 4.
  - After the ack, second frame carries bytes 5..6.
- **Reset mid-frame.** Assert `aresetn=0` during SEND_DATA.
  - `m_axis_tvalid` goes to 0 asynchronously and `seq_bit=0`.
  - After release, a new frame is sent with header 0x00.
